// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM sequencing controller.
//   - op_e    : host command encodings carried on req_op
//   - state_e : controller FSM states
//   - default word width and erased-word value
package eeprom_pkg;

    localparam int          DATA_W_DEF     = 16;
    localparam logic [15:0] ERASED_VAL_DEF = 16'h0000;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_ERASE   = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_ERASE,
        ST_PROG,
        ST_VERIFY,
        ST_RESP
    } state_e;

endpackage

// File: rtl/eeprom_pulse_timer.sv
// Loadable 8-bit down-counter that times the erase and program pulses.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : load load_val on the next edge (takes priority over counting)
//   load_val   : pulse width in cycles, 1..255
//   done       : high in the last cycle of the timed interval
// The counter free-runs down to zero and parks there until reloaded, so a
// value of N loaded on an edge gives exactly N cycles before done's cycle ends.
module eeprom_pulse_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        // NOTE: defaulting every always_comb output first keeps any path from
        // leaving it unassigned, which is what would otherwise infer a latch.
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == 8'd1);

endmodule

// File: rtl/eeprom_ctrl.sv
// Sequencing controller for a 16-word x 16-bit EEPROM.
//   Host side : req_valid/req_ready/req_op/req_addr/req_wdata command input,
//               rsp_valid/rsp_rdata/rsp_err one-cycle response, busy,
//               err_count (saturating count of error responses).
//   EEPROM    : ee_addr, ee_we, ee_erase, ee_wdata out; ee_rdata in
//               (combinational read of ee_addr).
// A WRITE is erase, program, verify; an ERASE is erase, verify; a READ is a
// single-cycle sample. The response pulse is registered out of RESP, so it
// appears in the IDLE cycle that follows, when the next command can be taken.
module eeprom_ctrl
    import eeprom_pkg::*;
#(
    parameter int                 ADDR_W       = 4,
    parameter int                 DATA_W       = DATA_W_DEF,
    parameter int unsigned        ERASE_CYCLES = 4,
    parameter int unsigned        PROG_CYCLES  = 4,
    parameter logic [DATA_W-1:0]  ERASED_VAL   = DATA_W'(ERASED_VAL_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] ee_addr,
    output logic              ee_we,
    output logic              ee_erase,
    output logic [DATA_W-1:0] ee_wdata,
    input  logic [DATA_W-1:0] ee_rdata
);

    state_e              state_q,     state_d;
    op_e                 op_q,        op_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                err_pend_q,  err_pend_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q,   rsp_err_d;
    logic [7:0]          err_count_q, err_count_d;

    logic                timer_load;
    logic [7:0]          timer_val;
    logic                timer_done;
    logic [DATA_W-1:0]   verify_exp;

    eeprom_pulse_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    assign verify_exp = (op_q == OP_WRITE) ? wdata_q : ERASED_VAL;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        err_pend_d  = err_pend_q;
        timer_load  = 1'b0;
        timer_val   = 8'(ERASE_CYCLES);
        rsp_valid_d = (state_q == ST_RESP);
        rsp_err_d   = (state_q == ST_RESP) && err_pend_q;
        err_count_d = err_count_q;

        if (rsp_valid_q && rsp_err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d       = op_e'(req_op);
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    err_pend_d = 1'b0;
                    case (op_e'(req_op))
                        OP_READ:  state_d = ST_READ;
                        OP_WRITE,
                        OP_ERASE: begin
                            state_d    = ST_ERASE;
                            timer_load = 1'b1;
                            timer_val  = 8'(ERASE_CYCLES);
                        end
                        default: begin
                            state_d     = ST_RESP;
                            err_pend_d  = 1'b1;
                            rsp_rdata_d = '0;
                        end
                    endcase
                end
            end
            ST_READ: begin
                rsp_rdata_d = ee_rdata;
                state_d     = ST_RESP;
            end
            ST_ERASE: begin
                if (timer_done) begin
                    if (op_q == OP_WRITE) begin
                        state_d    = ST_PROG;
                        timer_load = 1'b1;
                        timer_val  = 8'(PROG_CYCLES);
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
            end
            ST_PROG: begin
                if (timer_done) begin
                    state_d = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                rsp_rdata_d = ee_rdata;
                err_pend_d  = (ee_rdata != verify_exp);
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            err_pend_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_pend_q  <= err_pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            err_count_q <= err_count_d;
        end
    end

    // Pulse pins decode the state register directly, so they fall the moment
    // rst_n goes low and can never both be high in one cycle.
    assign ee_erase  = (state_q == ST_ERASE);
    assign ee_we     = (state_q == ST_PROG);
    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign ee_addr   = addr_q;
    assign ee_wdata  = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_eeprom_ctrl.sv
// Self-checking bench for eeprom_ctrl: directed test-plan steps followed by
// random commands, compared against a word-level model of the EEPROM contents.
module tb_eeprom_ctrl;
    import eeprom_pkg::*;

    localparam int          E      = 4;
    localparam int          P      = 4;
    localparam logic [15:0] ERASED = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [3:0]  req_addr = 4'd0;
    logic [15:0] req_wdata = 16'd0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  err_count;
    logic [3:0]  ee_addr;
    logic        ee_we;
    logic        ee_erase;
    logic [15:0] ee_wdata;
    logic [15:0] ee_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    eeprom_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .err_count (err_count),
        .ee_addr   (ee_addr),
        .ee_we     (ee_we),
        .ee_erase  (ee_erase),
        .ee_wdata  (ee_wdata),
        .ee_rdata  (ee_rdata)
    );

    // EEPROM device: erase clears the word, program stores write_data.
    logic [15:0] chip [16] = '{default: 16'h5A5A};
    logic        force_en = 1'b0;
    assign ee_rdata = force_en ? 16'h00DC : chip[ee_addr];

    always @(posedge clk) begin
        if (ee_erase)   chip[ee_addr] <= ERASED;
        else if (ee_we) chip[ee_addr] <= ee_wdata;
    end

    // Pin monitor: cumulative counts sampled mid-cycle.
    int         erase_tot = 0, we_tot = 0, overlap_tot = 0, addr_bad_tot = 0, rsp_tot = 0;
    logic [3:0] mon_addr = 4'd0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ee_erase)              erase_tot++;
            if (ee_we)                 we_tot++;
            if (ee_erase && ee_we)     overlap_tot++;
            if (busy && ee_addr !== mon_addr) addr_bad_tot++;
            if (rsp_valid)             rsp_tot++;
        end
    end

    // Reference model: word contents and error count.
    logic [15:0] ref_mem [16] = '{default: 16'h5A5A};
    int          ref_errs = 0;

    function automatic int exp_latency(input logic [1:0] op);
        case (op)
            2'b00:   return 2;
            2'b01:   return E + P + 2;
            2'b10:   return E + 2;
            default: return 1;
        endcase
    endfunction

    task automatic model_cmd(input logic [1:0] op, input logic [3:0] a, input logic [15:0] d,
                             output logic [15:0] exp_rdata, output logic exp_err);
        exp_err = 1'b0;
        case (op)
            2'b00: exp_rdata = ref_mem[a];
            2'b01: begin ref_mem[a] = d; exp_rdata = d; end
            2'b10: begin ref_mem[a] = ERASED; exp_rdata = ERASED; end
            default: begin exp_rdata = 16'h0000; exp_err = 1'b1; end
        endcase
        if (exp_err && ref_errs < 255) ref_errs++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [3:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rdata, input logic exp_err, input string tag);
        int  e0, w0, ov0, ab0, k, rb, lat;
        bit  seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d; mon_addr = a;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        e0 = erase_tot; w0 = we_tot; ov0 = overlap_tot; ab0 = addr_bad_tot;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0; rb = 0; seen = 0;
        while (!seen && k < 300) begin
            if (req_ready !== 1'b0) rb++;
            @(posedge clk); #1;
            k++;
            if (rsp_valid === 1'b1) seen = 1;
        end
        lat = seen ? k : -1;
        check({tag, "_lat"},     32'(lat), 32'(exp_latency(op)));
        check({tag, "_rdata"},   32'(rsp_rdata), 32'(exp_rdata));
        check({tag, "_err"},     32'(rsp_err), 32'(exp_err));
        check({tag, "_busy_rdy"}, 32'(rb), 32'd0);
        check({tag, "_erase_n"}, 32'(erase_tot - e0), 32'((op == 2'b01 || op == 2'b10) ? E : 0));
        check({tag, "_we_n"},    32'(we_tot - w0), 32'((op == 2'b01) ? P : 0));
        check({tag, "_overlap"}, 32'(overlap_tot - ov0), 32'd0);
        check({tag, "_addr"},    32'(addr_bad_tot - ab0), 32'd0);
        @(posedge clk); #1;
        check({tag, "_pulse1"},  32'(rsp_valid), 32'd0);
        check({tag, "_errcnt"},  32'(err_count), 32'(ref_errs));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] xr;
        logic        xe;
        logic [1:0]  rop;
        logic [3:0]  ra;
        logic [15:0] rd;
        int          rsp0, k, lat;
        bit          seen;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready",  32'(req_ready), 32'd1);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_rsp",    32'(rsp_valid), 32'd0);
        check("rst_pins",   32'({ee_we, ee_erase}), 32'd0);
        check("rst_errcnt", 32'(err_count), 32'd0);
        check("rst_addr",   32'({ee_addr, ee_wdata}), 32'd0);
        check("rst_rdata",  32'({rsp_rdata, rsp_err}), 32'd0);

        // 1: write then read back.
        model_cmd(2'b01, 4'd2, 16'h00AA, xr, xe); do_cmd(2'b01, 4'd2, 16'h00AA, xr, xe, "t1_wr");
        model_cmd(2'b00, 4'd2, 16'h0000, xr, xe); do_cmd(2'b00, 4'd2, 16'h0000, xr, xe, "t1_rd");

        // 2: preload, erase, read back.
        model_cmd(2'b01, 4'd5, 16'h1234, xr, xe); do_cmd(2'b01, 4'd5, 16'h1234, xr, xe, "t2_pre");
        model_cmd(2'b10, 4'd5, 16'h0000, xr, xe); do_cmd(2'b10, 4'd5, 16'h0000, xr, xe, "t2_er");
        model_cmd(2'b00, 4'd5, 16'h0000, xr, xe); do_cmd(2'b00, 4'd5, 16'h0000, xr, xe, "t2_rd");

        // 3: verify mismatch at top address.
        model_cmd(2'b01, 4'd15, 16'h00DD, xr, xe);
        ref_errs++;
        force_en = 1'b1;
        do_cmd(2'b01, 4'd15, 16'h00DD, 16'h00DC, 1'b1, "t3_vfy");
        force_en = 1'b0;

        // 4: illegal op.
        model_cmd(2'b11, 4'd9, 16'hFFFF, xr, xe); do_cmd(2'b11, 4'd9, 16'hFFFF, xr, xe, "t4_ill");

        // 5: reset during the 2nd PROG cycle.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_addr = 4'd7; req_wdata = 16'h0777; mon_addr = 4'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp0 = rsp_tot;
        repeat (E) @(posedge clk);
        @(posedge clk); #1;
        check("t5_we_before", 32'(ee_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_we_async",  32'({ee_we, ee_erase}), 32'd0);
        check("t5_ready_rst", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ref_errs = 0;
        repeat (12) @(posedge clk);
        #1;
        check("t5_no_rsp",  32'(rsp_tot - rsp0), 32'd0);
        check("t5_ready",   32'(req_ready), 32'd1);
        check("t5_errcnt",  32'(err_count), 32'd0);
        model_cmd(2'b01, 4'd7, 16'h0777, xr, xe); do_cmd(2'b01, 4'd7, 16'h0777, xr, xe, "t5_rewr");

        // 6: back-to-back WRITE then READ with req_valid held high.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_addr = 4'd4; req_wdata = 16'h00BB; mon_addr = 4'd4;
        ref_mem[4] = 16'h00BB;
        @(posedge clk); #1;
        req_op = 2'b00; req_wdata = 16'h0000;
        k = 0; seen = 0; rsp0 = 0;
        while (!seen && k < 300) begin
            if (req_ready !== 1'b0) rsp0++;
            @(posedge clk); #1;
            k++;
            if (rsp_valid === 1'b1) seen = 1;
        end
        lat = seen ? k : -1;
        check("t6_wr_lat",   32'(lat), 32'(E + P + 2));
        check("t6_wr_rdy",   32'(rsp0), 32'd0);
        check("t6_wr_rdata", 32'(rsp_rdata), 32'h00BB);
        check("t6_rdy_resp", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("t6_rd_taken", 32'(req_ready), 32'd0);
        k = 0; seen = 0;
        while (!seen && k < 300) begin
            @(posedge clk); #1;
            k++;
            if (rsp_valid === 1'b1) seen = 1;
        end
        lat = seen ? k : -1;
        check("t6_rd_lat",   32'(lat), 32'd2);
        check("t6_rd_rdata", 32'(rsp_rdata), 32'(ref_mem[4]));
        check("t6_rd_err",   32'(rsp_err), 32'd0);

        // Random commands against the model.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 4'($urandom_range(0, 15));
            rd  = 16'($urandom);
            model_cmd(rop, ra, rd, xr, xe);
            do_cmd(rop, ra, rd, xr, xe, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
